// File: rtl/expr_share_arb.sv
// Two-requester arbiter time-sharing one combinational expression datapath.
// Optional feature: define EXPR_SHARE_ARB_CHKSUM_EN to add the resp_chk checksum output.
module expr_share_arb #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [59:0] req_ops0,
    input  logic [59:0] req_ops1,
    output logic [59:0] dp_ops,
    input  logic [89:0] dp_y,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [89:0] resp_y,
    output logic        busy
`ifdef EXPR_SHARE_ARB_CHKSUM_EN
    ,
    output logic [7:0]  resp_chk
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        last_grant_q;
    logic        owner_q;
    logic [59:0] dp_ops_q;
    logic [89:0] resp_y_q;
    logic [1:0]  resp_valid_q;

    logic        grantIdx;
    logic        anyReq;
    logic        respDone;

    assign anyReq   = |req_valid;
    assign respDone = |(resp_valid_q & resp_ready);

    // On a tie the requester that did not win last time gets the datapath.
    always_comb begin
        grantIdx = 1'b0;
        if (req_valid == 2'b11) begin
            grantIdx = ~last_grant_q;
        end else if (req_valid == 2'b10) begin
            grantIdx = 1'b1;
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (state_q == IDLE) && anyReq) begin
            req_ready = grantIdx ? 2'b10 : 2'b01;
        end
    end

`ifdef EXPR_SHARE_ARB_CHKSUM_EN
    logic [7:0] chk_d;
    logic [7:0] chk_q;

    always_comb begin
        chk_d = {6'b000000, dp_y[89:88]};
        for (int i = 0; i < 11; i++) begin
            chk_d = chk_d ^ dp_y[i*8 +: 8];
        end
    end

    assign resp_chk = chk_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            dp_ops_q     <= '0;
            resp_y_q     <= '0;
            resp_valid_q <= 2'b00;
`ifdef EXPR_SHARE_ARB_CHKSUM_EN
            chk_q        <= 8'h00;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        owner_q      <= grantIdx;
                        last_grant_q <= grantIdx;
                        dp_ops_q     <= grantIdx ? req_ops1 : req_ops0;
                        cnt_q        <= CNT_INIT;
                        state_q      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 2'd0) begin
                        resp_y_q     <= dp_y;
                        resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q      <= RESP;
`ifdef EXPR_SHARE_ARB_CHKSUM_EN
                        chk_q        <= chk_d;
`endif
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    // Only the owner's resp_ready can complete the handshake.
                    if (respDone) begin
                        resp_valid_q <= 2'b00;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 2'b00;
                end
            endcase
        end
    end

    assign dp_ops     = dp_ops_q;
    assign resp_y     = resp_y_q;
    assign resp_valid = resp_valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_expr_share_arb.sv
// Directed bench for expr_share_arb: a LAT=1 instance driven from a vector table,
// and a LAT=4 instance for settle timing and mid-transaction reset.
module tb_expr_share_arb;

    logic        clk;
    logic        rstN;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [59:0] reqOps0;
    logic [59:0] reqOps1;
    logic [59:0] dpOps;
    logic [89:0] dpY;
    logic [1:0]  respValid;
    logic [1:0]  respReady;
    logic [89:0] respY;
    logic        busy;

    logic        rstN4;
    logic [1:0]  reqValid4;
    logic [1:0]  reqReady4;
    logic [59:0] reqOps04;
    logic [59:0] reqOps14;
    logic [59:0] dpOps4;
    logic [89:0] dpY4;
    logic [1:0]  respValid4;
    logic [1:0]  respReady4;
    logic [89:0] respY4;
    logic        busy4;

`ifdef EXPR_SHARE_ARB_CHKSUM_EN
    logic [7:0]  respChk;
    logic [7:0]  respChk4;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [59:0] OPS_A = {60{1'b1}};
    localparam logic [59:0] OPS_B = 60'h1234_5678_9AB_CDEF;

    expr_share_arb #(.LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req_ops0   (reqOps0),
        .req_ops1   (reqOps1),
        .dp_ops     (dpOps),
        .dp_y       (dpY),
        .resp_valid (respValid),
        .resp_ready (respReady),
        .resp_y     (respY),
`ifdef EXPR_SHARE_ARB_CHKSUM_EN
        .resp_chk   (respChk),
`endif
        .busy       (busy)
    );

    expr_share_arb #(.LAT(4)) dut4 (
        .clk        (clk),
        .rst_n      (rstN4),
        .req_valid  (reqValid4),
        .req_ready  (reqReady4),
        .req_ops0   (reqOps04),
        .req_ops1   (reqOps14),
        .dp_ops     (dpOps4),
        .dp_y       (dpY4),
        .resp_valid (respValid4),
        .resp_ready (respReady4),
        .resp_y     (respY4),
`ifdef EXPR_SHARE_ARB_CHKSUM_EN
        .resp_chk   (respChk4),
`endif
        .busy       (busy4)
    );

    // Reference expression: six lane products a_i*b_i, each in a 15-bit field.
    function automatic logic [89:0] yModel(input logic [59:0] o);
        logic [14:0] p0, p1, p2, p3, p4, p5;
        p0 = 15'(o[59:56]) * 15'(o[29:26]);
        p1 = 15'(o[55:51]) * 15'(o[25:21]);
        p2 = 15'(o[50:45]) * 15'(o[20:15]);
        p3 = 15'(o[44:41]) * 15'(o[14:11]);
        p4 = 15'(o[40:36]) * 15'(o[10:6]);
        p5 = 15'(o[35:30]) * 15'(o[5:0]);
        return {p0, p1, p2, p3, p4, p5};
    endfunction

`ifdef EXPR_SHARE_ARB_CHKSUM_EN
    function automatic logic [7:0] chkModel(input logic [89:0] y);
        logic [7:0] c;
        c = {6'b000000, y[89:88]};
        for (int i = 0; i < 11; i++) c = c ^ y[i*8 +: 8];
        return c;
    endfunction
`endif

    always_comb dpY  = yModel(dpOps);
    always_comb dpY4 = yModel(dpOps4);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rv;
        logic [1:0] rr;
        logic [1:0] expReady;
        logic       expBusy;
        logic [1:0] expRespV;
        logic [1:0] opSel;
    } vec_t;

    vec_t vecs[18];

    task automatic checkOutput(input string name, input logic [89:0] act, input logic [89:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] rv, input logic [1:0] rr);
        reqValid  = rv;
        respReady = rr;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [59:0] opsOf(input logic [1:0] sel);
        return (sel == 2'd2) ? OPS_B : OPS_A;
    endfunction

    initial begin
        vecs[0]  = '{2'b11, 2'b11, 2'b01, 1'b0, 2'b00, 2'd0};
        vecs[1]  = '{2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 2'd1};
        vecs[2]  = '{2'b11, 2'b11, 2'b00, 1'b1, 2'b01, 2'd1};
        vecs[3]  = '{2'b11, 2'b00, 2'b10, 1'b0, 2'b00, 2'd0};
        vecs[4]  = '{2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 2'd2};
        vecs[5]  = '{2'b11, 2'b01, 2'b00, 1'b1, 2'b10, 2'd2};
        vecs[6]  = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 2'd2};
        vecs[7]  = '{2'b00, 2'b10, 2'b00, 1'b1, 2'b10, 2'd2};
        vecs[8]  = '{2'b01, 2'b00, 2'b01, 1'b0, 2'b00, 2'd0};
        vecs[9]  = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'd1};
        vecs[10] = '{2'b00, 2'b01, 2'b00, 1'b1, 2'b01, 2'd1};
        vecs[11] = '{2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 2'd0};
        vecs[12] = '{2'b10, 2'b00, 2'b00, 1'b1, 2'b00, 2'd2};
        vecs[13] = '{2'b10, 2'b10, 2'b00, 1'b1, 2'b10, 2'd2};
        vecs[14] = '{2'b11, 2'b00, 2'b01, 1'b0, 2'b00, 2'd0};
        vecs[15] = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'd1};
        vecs[16] = '{2'b00, 2'b01, 2'b00, 1'b1, 2'b01, 2'd1};
        vecs[17] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0};

        rstN = 1'b0;  reqValid = 2'b00;  respReady = 2'b00;
        reqOps0 = OPS_A;  reqOps1 = OPS_B;
        rstN4 = 1'b0; reqValid4 = 2'b00; respReady4 = 2'b00;
        reqOps04 = OPS_B; reqOps14 = OPS_A;

        // Reset state, with requests pending while reset is held.
        nextCycle();
        applyStimulus(2'b11, 2'b11);
        checkOutput("rst_req_ready", 90'(reqReady), 90'(2'b00));
        checkOutput("rst_busy", 90'(busy), 90'(1'b0));
        checkOutput("rst_resp_valid", 90'(respValid), 90'(2'b00));
        checkOutput("rst_dp_ops", 90'(dpOps), 90'd0);
        checkOutput("rst_resp_y", respY, 90'd0);
        checkOutput("rst4_busy", 90'(busy4), 90'(1'b0));
        nextCycle();
        rstN = 1'b1;
        rstN4 = 1'b1;

        // Table-driven sequence on the LAT=1 instance.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rv, vecs[i].rr);
            checkOutput($sformatf("v%0d_req_ready", i), 90'(reqReady), 90'(vecs[i].expReady));
            checkOutput($sformatf("v%0d_busy", i), 90'(busy), 90'(vecs[i].expBusy));
            checkOutput($sformatf("v%0d_resp_valid", i), 90'(respValid), 90'(vecs[i].expRespV));
            if (vecs[i].expBusy) begin
                checkOutput($sformatf("v%0d_dp_ops", i), 90'(dpOps), 90'(opsOf(vecs[i].opSel)));
            end
            if (vecs[i].expRespV != 2'b00) begin
                checkOutput($sformatf("v%0d_resp_y", i), respY, yModel(opsOf(vecs[i].opSel)));
`ifdef EXPR_SHARE_ARB_CHKSUM_EN
                checkOutput($sformatf("v%0d_resp_chk", i), 90'(respChk), 90'(chkModel(yModel(opsOf(vecs[i].opSel)))));
`endif
            end
            nextCycle();
        end

        // Response back-pressure: hold resp_ready low for 10 cycles in RESP.
        applyStimulus(2'b01, 2'b00);
        checkOutput("hold_grant", 90'(reqReady), 90'(2'b01));
        nextCycle();
        applyStimulus(2'b10, 2'b00);
        nextCycle();
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("hold%0d_resp_valid", k), 90'(respValid), 90'(2'b01));
            checkOutput($sformatf("hold%0d_resp_y", k), respY, yModel(OPS_A));
            checkOutput($sformatf("hold%0d_req_ready", k), 90'(reqReady), 90'(2'b00));
            checkOutput($sformatf("hold%0d_dp_ops", k), 90'(dpOps), 90'(OPS_A));
            nextCycle();
        end
        applyStimulus(2'b00, 2'b01);
        checkOutput("hold_release_valid", 90'(respValid), 90'(2'b01));
        nextCycle();
        applyStimulus(2'b00, 2'b00);
        checkOutput("hold_release_busy", 90'(busy), 90'(1'b0));
        checkOutput("hold_release_resp_valid", 90'(respValid), 90'(2'b00));

        // LAT=4: response rises exactly four edges after the grant edge.
        reqValid4 = 2'b01;
        #1;
        checkOutput("lat4_grant", 90'(reqReady4), 90'(2'b01));
        nextCycle();
        reqValid4 = 2'b00;
        checkOutput("lat4_e0_busy", 90'(busy4), 90'(1'b1));
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            checkOutput($sformatf("lat4_e%0d_busy", k), 90'(busy4), 90'(1'b1));
            checkOutput($sformatf("lat4_e%0d_resp_valid", k), 90'(respValid4), 90'((k == 4) ? 2'b01 : 2'b00));
        end
        checkOutput("lat4_resp_y", respY4, yModel(OPS_B));
        respReady4 = 2'b01;
        nextCycle();
        respReady4 = 2'b00;
        checkOutput("lat4_done_busy", 90'(busy4), 90'(1'b0));

        // Reset during SETTLE aborts the request and restores requester 0 priority.
        reqValid4 = 2'b01;
        #1;
        checkOutput("abort_grant", 90'(reqReady4), 90'(2'b01));
        nextCycle();
        reqValid4 = 2'b11;
        rstN4 = 1'b0;
        #1;
        checkOutput("abort_ready_in_reset", 90'(reqReady4), 90'(2'b00));
        nextCycle();
        checkOutput("abort_busy", 90'(busy4), 90'(1'b0));
        checkOutput("abort_resp_valid", 90'(respValid4), 90'(2'b00));
        checkOutput("abort_dp_ops", 90'(dpOps4), 90'd0);
        checkOutput("abort_resp_y", respY4, 90'd0);
        rstN4 = 1'b1;
        #1;
        checkOutput("abort_tie_prio", 90'(reqReady4), 90'(2'b01));
        nextCycle();
        reqValid4 = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            checkOutput($sformatf("abort_e%0d_resp_valid", k), 90'(respValid4), 90'((k == 4) ? 2'b01 : 2'b00));
        end
        checkOutput("abort_resp_y_new", respY4, yModel(OPS_B));
        respReady4 = 2'b01;
        nextCycle();
        respReady4 = 2'b00;
        checkOutput("abort_done_busy", 90'(busy4), 90'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
